conv_mac_stream: RTL

- Convolution datapath stage that sits directly upstream of the output FIFO.
- Accepts a stream of signed {weight, pixel} pairs over AXI-Stream.
- Multiplies each pair and accumulates K*K consecutive products into one OUTW-bit window result.
- Presents each result on an AXI-Stream master that drives the output FIFO's input.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_mac_stream.sv | 93 +++++++++
 2 files changed

// File: rtl/conv_pkg.sv
// Shared types and default sizing for the convolution MAC stage and its output FIFO.
// The optional ReLU clamp is selected by the CONV_MAC_RELU_EN macro in conv_mac_stream.
package conv_pkg;

  localparam int INW   = 8;
  localparam int K     = 3;
  localparam int OUTW  = 24;
  localparam int NTAPS = K * K;

  typedef logic signed [INW-1:0]   pixel_t;
  typedef logic signed [INW-1:0]   weight_t;
  typedef logic signed [2*INW-1:0] prod_t;
  typedef logic signed [OUTW-1:0]  result_t;

  function automatic result_t sext_prod(input prod_t p);
    return {{(OUTW - 2*INW){p[2*INW-1]}}, p};
  endfunction

endpackage

// File: rtl/conv_mac_stream.sv
// Streaming multiply-accumulate: K*K signed {weight,pixel} pairs -> one OUTW-bit window sum.
// Define CONV_MAC_RELU_EN to clamp negative window sums to zero at the output register.
module conv_mac_stream #(
  parameter int INW  = conv_pkg::INW,
  parameter int K    = conv_pkg::K,
  parameter int OUTW = conv_pkg::OUTW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2*INW-1:0]  IN_AXIS_TDATA,
  input  logic              IN_AXIS_TVALID,
  output logic              IN_AXIS_TREADY,
  output logic [OUTW-1:0]   OUT_AXIS_TDATA,
  output logic              OUT_AXIS_TVALID,
  input  logic              OUT_AXIS_TREADY
);
  import conv_pkg::*;

  localparam int NT = K * K;
  localparam int CW = (NT > 1) ? $clog2(NT) : 1;

  if (OUTW < 2*INW + $clog2(K*K)) begin : g_outw_check
    $error("conv_mac_stream: OUTW too narrow to hold K*K full-scale products");
  end

  logic                   r_p_valid;
  logic signed [2*INW-1:0] r_p;
  logic [OUTW-1:0]        r_acc;
  logic [CW-1:0]          r_cnt;
  logic [OUTW-1:0]        r_out_data;
  logic                   r_out_valid;

  logic                   w_adv;
  logic                   w_in_fire;
  logic                   w_last;
  logic signed [INW-1:0]  w_weight;
  logic signed [INW-1:0]  w_pixel;
  logic signed [2*INW-1:0] w_prod;
  logic [OUTW-1:0]        w_p_ext;
  logic [OUTW-1:0]        w_sum;
  logic [OUTW-1:0]        w_final;

  // A held result freezes every stage, so the input side stalls with it.
  assign w_adv     = !r_out_valid || OUT_AXIS_TREADY;
  assign w_in_fire = IN_AXIS_TVALID && w_adv;

  assign w_weight = IN_AXIS_TDATA[2*INW-1:INW];
  assign w_pixel  = IN_AXIS_TDATA[INW-1:0];
  assign w_prod   = w_weight * w_pixel;

  assign w_p_ext = {{(OUTW - 2*INW){r_p[2*INW-1]}}, r_p};
  assign w_sum   = r_acc + w_p_ext;
  assign w_last  = (r_cnt == CW'(NT - 1));

`ifdef CONV_MAC_RELU_EN
  assign w_final = w_sum[OUTW-1] ? '0 : w_sum;
`else
  assign w_final = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p_valid   <= 1'b0;
      r_p         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      r_p_valid <= w_in_fire;
      if (w_in_fire) begin
        r_p <= w_prod;
      end
      // Advancing with valid high implies a handshake, so valid only survives via a new load.
      r_out_valid <= r_p_valid && w_last;
      if (r_p_valid) begin
        if (w_last) begin
          r_out_data <= w_final;
          r_acc      <= w_sum;
          r_cnt      <= '0;
        end else begin
          r_acc <= (r_cnt == '0) ? w_p_ext : w_sum;
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign IN_AXIS_TREADY  = w_adv;
  assign OUT_AXIS_TDATA  = r_out_data;
  assign OUT_AXIS_TVALID = r_out_valid;

endmodule
